// File: rtl/skew_delay_ctrl.sv
// skew_delay_ctrl
// Sequences one tile pass through a ROWS-high systolic array. A start command
// launches a diagonally skewed row-enable wavefront lasting i_len columns, then
// the block waits out the downstream delay-line latency (DRAIN cycles after the
// last row enable) and emits a single-cycle done pulse.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   i_start   start request, accepted only while o_ready=1
//   i_len     tile length in columns, sampled on acceptance (0 = immediate done)
//   i_abort   synchronous abort, overrides everything except reset
//   o_ready   high in IDLE only
//   o_busy    complement of o_ready
//   o_row_en  skewed row enables, bit k = bit 0 delayed k cycles
//   o_done    one-cycle completion pulse
// All outputs are registered.

module skew_delay_ctrl #(
  parameter int ROWS  = 8,
  parameter int LEN_W = 8,
  parameter int DRAIN = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_abort,
  output logic             o_ready,
  output logic             o_busy,
  output logic [ROWS-1:0]  o_row_en,
  output logic             o_done
);

  localparam int DW = $clog2(ROWS + DRAIN) + 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(ROWS - 1 + DRAIN);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN} state_t;

  state_t           state, state_n;
  logic [LEN_W-1:0] feed_cnt, feed_cnt_n;
  logic [DW-1:0]    drain_cnt, drain_cnt_n;
  logic             row0_n;
  logic             done_n;
  logic [ROWS-1:0]  row_en_n;

  always_comb begin
    state_n     = state;
    feed_cnt_n  = feed_cnt;
    drain_cnt_n = drain_cnt;
    row0_n      = 1'b0;
    done_n      = 1'b0;
    if (i_abort) begin
      state_n     = S_IDLE;
      feed_cnt_n  = '0;
      drain_cnt_n = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            if (i_len != '0) begin
              state_n    = S_FEED;
              feed_cnt_n = i_len;
              row0_n     = 1'b1;
            end else begin
              done_n = 1'b1;
            end
          end
        end
        S_FEED: begin
          // feed_cnt holds the number of row-0 cycles still owed including the
          // current one; the last one leaves row 0 low on the next edge.
          if (feed_cnt == LEN_W'(1)) begin
            state_n     = S_DRAIN;
            feed_cnt_n  = '0;
            drain_cnt_n = DRAIN_LOAD;
          end else begin
            feed_cnt_n = feed_cnt - LEN_W'(1);
            row0_n     = 1'b1;
          end
        end
        S_DRAIN: begin
          // The counter value seen on the DRAIN-entry edge counts as one cycle
          // and the registered done adds another, so finish when two remain.
          if (drain_cnt == DW'(2)) begin
            state_n     = S_IDLE;
            drain_cnt_n = '0;
            done_n      = 1'b1;
          end else begin
            drain_cnt_n = drain_cnt - DW'(1);
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Row k is row 0 delayed k cycles: the upper bits form the skew pipe.
  always_comb begin
    row_en_n = '0;
    if (!i_abort)
      row_en_n = {o_row_en[ROWS-2:0], row0_n};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      feed_cnt  <= '0;
      drain_cnt <= '0;
      o_row_en  <= '0;
      o_done    <= 1'b0;
      o_ready   <= 1'b1;
      o_busy    <= 1'b0;
    end else begin
      state     <= state_n;
      feed_cnt  <= feed_cnt_n;
      drain_cnt <= drain_cnt_n;
      o_row_en  <= row_en_n;
      o_done    <= done_n;
      o_ready   <= (state_n == S_IDLE);
      o_busy    <= (state_n != S_IDLE);
    end
  end

endmodule

// File: tb/tb_skew_delay_ctrl.sv
// Testbench for skew_delay_ctrl (ROWS=4, LEN_W=4, DRAIN=3).
// Expected per-cycle outputs are derived from job timing formulas, pushed to a
// scoreboard queue before stimulus is applied, and popped one per cycle.
// Sample index s is the value seen just after posedge s of a test window.

module tb_skew_delay_ctrl;

  localparam int ROWS  = 4;
  localparam int LEN_W = 4;
  localparam int DRAIN = 3;
  localparam int MAXN  = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_start;
  logic [LEN_W-1:0] i_len;
  logic             i_abort;
  logic             o_ready;
  logic             o_busy;
  logic [ROWS-1:0]  o_row_en;
  logic             o_done;

  skew_delay_ctrl #(.ROWS(ROWS), .LEN_W(LEN_W), .DRAIN(DRAIN)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_len(i_len),
    .i_abort(i_abort), .o_ready(o_ready), .o_busy(o_busy),
    .o_row_en(o_row_en), .o_done(o_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ROWS-1:0] row;
    logic            done;
    logic            ready;
  } exp_t;

  exp_t sb[$];
  exp_t ex;

  logic [ROWS-1:0]  e_row   [MAXN];
  logic             e_done  [MAXN];
  logic             e_ready [MAXN];
  logic             st_start[MAXN];
  logic [LEN_W-1:0] st_len  [MAXN];
  logic             st_abort[MAXN];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void clear_plan();
    for (int i = 0; i < MAXN; i++) begin
      e_row[i] = '0; e_done[i] = 1'b0; e_ready[i] = 1'b1;
      st_start[i] = 1'b0; st_len[i] = '0; st_abort[i] = 1'b0;
    end
  endfunction

  // Job accepted at edge a with length len; cut = first sample forced idle by abort.
  function automatic void plan_job(int a, int len, int cut);
    int d;
    st_start[a] = 1'b1;
    st_len[a]   = LEN_W'(len);
    if (len == 0) begin
      if (a < cut) e_done[a] = 1'b1;
      return;
    end
    for (int k = 0; k < ROWS; k++)
      for (int s = a + k; s <= a + len - 1 + k; s++)
        if (s < cut && s < MAXN) e_row[s][k] = 1'b1;
    d = a + len + ROWS - 2 + DRAIN;
    for (int s = a; s < d; s++)
      if (s < cut && s < MAXN) e_ready[s] = 1'b0;
    if (d < cut && d < MAXN) e_done[d] = 1'b1;
  endfunction

  function automatic void push_plan(int n);
    for (int s = 0; s < n; s++) sb.push_back('{row: e_row[s], done: e_done[s], ready: e_ready[s]});
  endfunction

  task automatic idle_inputs();
    i_start = 1'b0; i_len = '0; i_abort = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({o_row_en, o_done, o_ready, o_busy} !== {{ROWS{1'b0}}, 1'b0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL reset: got row=%b done=%b rdy=%b busy=%b, need row=0 done=0 rdy=1 busy=0",
               o_row_en, o_done, o_ready, o_busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_job();
    clear_plan();
    plan_job(0, 5, MAXN);
    push_plan(16);
    for (int e = 0; e < 16; e++) begin
      i_start = st_start[e]; i_len = st_len[e]; i_abort = st_abort[e];
      @(negedge clk);
      ex = sb.pop_front();
      n_cmp++;
      if ({o_row_en, o_done, o_ready} !== ex || o_busy !== !o_ready) begin
        n_bad++;
        $display("FAIL single s=%0d: got row=%b done=%b rdy=%b busy=%b, need row=%b done=%b rdy=%b",
                 e, o_row_en, o_done, o_ready, o_busy, ex.row, ex.done, ex.ready);
      end
    end
    idle_inputs();
  endtask

  task automatic test_zero_len();
    clear_plan();
    plan_job(0, 0, MAXN);
    plan_job(2, 0, MAXN);
    push_plan(6);
    for (int e = 0; e < 6; e++) begin
      i_start = st_start[e]; i_len = st_len[e]; i_abort = st_abort[e];
      @(negedge clk);
      ex = sb.pop_front();
      n_cmp++;
      if ({o_row_en, o_done, o_ready} !== ex || o_busy !== !o_ready) begin
        n_bad++;
        $display("FAIL zero_len s=%0d: got row=%b done=%b rdy=%b busy=%b, need row=%b done=%b rdy=%b",
                 e, o_row_en, o_done, o_ready, o_busy, ex.row, ex.done, ex.ready);
      end
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    clear_plan();
    plan_job(0, 5, MAXN);
    // Starts while busy, including the edge that raises done, are ignored.
    foreach (st_start[i]) if (i >= 2 && i <= 10 && i % 2 == 0) begin
      st_start[i] = 1'b1; st_len[i] = LEN_W'(3);
    end
    plan_job(11, 5, MAXN);
    push_plan(26);
    for (int e = 0; e < 26; e++) begin
      i_start = st_start[e]; i_len = st_len[e]; i_abort = st_abort[e];
      @(negedge clk);
      ex = sb.pop_front();
      n_cmp++;
      if ({o_row_en, o_done, o_ready} !== ex || o_busy !== !o_ready) begin
        n_bad++;
        $display("FAIL back_to_back s=%0d: got row=%b done=%b rdy=%b busy=%b, need row=%b done=%b rdy=%b",
                 e, o_row_en, o_done, o_ready, o_busy, ex.row, ex.done, ex.ready);
      end
    end
    idle_inputs();
  endtask

  task automatic test_abort();
    clear_plan();
    plan_job(0, 5, 3);             // abort during FEED
    st_abort[3] = 1'b1;
    plan_job(14, 5, 24);           // abort on the edge that would raise done
    st_abort[24] = 1'b1;
    st_start[28] = 1'b1; st_len[28] = LEN_W'(4); st_abort[28] = 1'b1;  // abort beats start
    push_plan(34);
    for (int e = 0; e < 34; e++) begin
      i_start = st_start[e]; i_len = st_len[e]; i_abort = st_abort[e];
      @(negedge clk);
      ex = sb.pop_front();
      n_cmp++;
      if ({o_row_en, o_done, o_ready} !== ex || o_busy !== !o_ready) begin
        n_bad++;
        $display("FAIL abort s=%0d: got row=%b done=%b rdy=%b busy=%b, need row=%b done=%b rdy=%b",
                 e, o_row_en, o_done, o_ready, o_busy, ex.row, ex.done, ex.ready);
      end
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    clear_plan();
    plan_job(0, 5, MAXN);
    push_plan(8);                  // stop mid-DRAIN (done would be at sample 10)
    for (int e = 0; e < 8; e++) begin
      i_start = st_start[e]; i_len = st_len[e]; i_abort = st_abort[e];
      @(negedge clk);
      ex = sb.pop_front();
      n_cmp++;
      if ({o_row_en, o_done, o_ready} !== ex || o_busy !== !o_ready) begin
        n_bad++;
        $display("FAIL async_pre s=%0d: got row=%b done=%b rdy=%b busy=%b, need row=%b done=%b rdy=%b",
                 e, o_row_en, o_done, o_ready, o_busy, ex.row, ex.done, ex.ready);
      end
    end
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_row_en, o_done, o_ready, o_busy} !== {{ROWS{1'b0}}, 1'b0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL async_reset: got row=%b done=%b rdy=%b busy=%b, need row=0 done=0 rdy=1 busy=0",
               o_row_en, o_done, o_ready, o_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_plan();
    push_plan(12);
    for (int e = 0; e < 12; e++) begin
      @(negedge clk);
      ex = sb.pop_front();
      n_cmp++;
      if ({o_row_en, o_done, o_ready} !== ex || o_busy !== !o_ready) begin
        n_bad++;
        $display("FAIL async_post s=%0d: got row=%b done=%b rdy=%b busy=%b, need row=%b done=%b rdy=%b",
                 e, o_row_en, o_done, o_ready, o_busy, ex.row, ex.done, ex.ready);
      end
    end
  endtask

  task automatic test_max_len();
    clear_plan();
    plan_job(0, 15, MAXN);
    push_plan(24);
    for (int e = 0; e < 24; e++) begin
      i_start = st_start[e]; i_len = st_len[e]; i_abort = st_abort[e];
      @(negedge clk);
      ex = sb.pop_front();
      n_cmp++;
      if ({o_row_en, o_done, o_ready} !== ex || o_busy !== !o_ready) begin
        n_bad++;
        $display("FAIL max_len s=%0d: got row=%b done=%b rdy=%b busy=%b, need row=%b done=%b rdy=%b",
                 e, o_row_en, o_done, o_ready, o_busy, ex.row, ex.done, ex.ready);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_zero_len();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_max_len();
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, need 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
